// File: rtl/mem_access_if.sv
// Wishbone-style classic bus between the memory-access stage and memory.
// master: cyc/stb/we/adr/sel/dat_o out, dat_i/ack/err in; slave mirrors it.
interface mem_access_if;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;
  logic        bus_err_i;

  modport master (
    output bus_cyc_o, bus_stb_o, bus_we_o,
    output bus_adr_o, bus_sel_o, bus_dat_o,
    input  bus_dat_i, bus_ack_i, bus_err_i
  );

  modport slave (
    input  bus_cyc_o, bus_stb_o, bus_we_o,
    input  bus_adr_o, bus_sel_o, bus_dat_o,
    output bus_dat_i, bus_ack_i, bus_err_i
  );
endinterface

// File: rtl/mem_access.sv
// bexkat1 memory-access stage: one bus transaction per load/store, else 1-cycle pass-through.
// Ports: clk_i, rst_n_i, execute inputs, write-back outputs, stall_o, fault_o, bus (master).
// Optional: define BUS_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES REQ cycles.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg_data1_i,
  input  logic [1:0]  reg_write_i,
  input  logic        halt_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] result_o,
  output logic [1:0]  reg_write_o,
  output logic        halt_o,
  output logic        stall_o,
  output logic        fault_o,
  mem_access_if.master bus
);

  localparam logic [3:0] T_LOAD  = 4'ha;
  localparam logic [3:0] T_STORE = 4'hb;

  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  logic [3:0]  typ;
  logic [1:0]  wsz;
  logic        is_mem;
  logic        is_half;
  logic        is_byte;
  logic        misalign;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [31:0] ldat;
  logic [1:0]  a_q;
  logic [1:0]  w_q;
  logic        abort;
  logic        done;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          tmo;
  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic tmo;
  assign tmo = 1'b0;
`endif

  assign typ     = ir_i[31:28];
  assign wsz     = ir_i[25:24];
  assign is_mem  = (typ == T_LOAD) || (typ == T_STORE);
  assign is_half = (wsz == 2'd1);
  assign is_byte = (wsz == 2'd2);

  // err (or timeout) takes priority over a simultaneous ack
  assign abort = bus.bus_err_i | tmo;
  assign done  = bus.bus_ack_i | abort;

  always_comb begin
    misalign = 1'b0;
    sel      = 4'b1111;
    wdat     = reg_data1_i;
    unique case (1'b1)
      is_byte: begin
        sel  = 4'b1000 >> result_i[1:0];
        wdat = {4{reg_data1_i[7:0]}};
      end
      is_half: begin
        misalign = result_i[0];
        sel      = result_i[1] ? 4'b0011 : 4'b1100;
        wdat     = {reg_data1_i[15:0], reg_data1_i[15:0]};
      end
      default: misalign = |result_i[1:0];
    endcase
  end

  // big-endian lane extraction from the captured width/offset
  always_comb begin
    ldat = bus.bus_dat_i;
    if (w_q == 2'd2) begin
      unique case (a_q)
        2'd0: ldat = {24'h0, bus.bus_dat_i[31:24]};
        2'd1: ldat = {24'h0, bus.bus_dat_i[23:16]};
        2'd2: ldat = {24'h0, bus.bus_dat_i[15:8]};
        default: ldat = {24'h0, bus.bus_dat_i[7:0]};
      endcase
    end else if (w_q == 2'd1) begin
      ldat = a_q[1] ? {16'h0, bus.bus_dat_i[15:0]}
                    : {16'h0, bus.bus_dat_i[31:16]};
    end
  end

  always_comb begin
    stall_o = 1'b0;
    if (state == IDLE) stall_o = is_mem && !misalign;
    else               stall_o = !done;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      ir_o          <= '0;
      pc_o          <= '0;
      result_o      <= '0;
      reg_write_o   <= '0;
      halt_o        <= 1'b0;
      fault_o       <= 1'b0;
      bus.bus_cyc_o <= 1'b0;
      bus.bus_stb_o <= 1'b0;
      bus.bus_we_o  <= 1'b0;
      bus.bus_adr_o <= '0;
      bus.bus_sel_o <= '0;
      bus.bus_dat_o <= '0;
      a_q           <= '0;
      w_q           <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt           <= '0;
`endif
    end else begin
      fault_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (is_mem && !misalign) begin
            bus.bus_cyc_o <= 1'b1;
            bus.bus_stb_o <= 1'b1;
            bus.bus_we_o  <= (typ == T_STORE);
            bus.bus_adr_o <= {result_i[31:2], 2'b00};
            bus.bus_sel_o <= sel;
            bus.bus_dat_o <= wdat;
            a_q           <= result_i[1:0];
            w_q           <= wsz;
            state         <= REQ;
`ifdef BUS_TIMEOUT_EN
            cnt           <= '0;
`endif
          end else begin
            ir_o        <= ir_i;
            pc_o        <= pc_i;
            result_o    <= result_i;
            reg_write_o <= is_mem ? 2'b00 : reg_write_i;
            halt_o      <= halt_i;
            fault_o     <= is_mem;
          end
        end
        default: begin
          if (done) begin
            bus.bus_cyc_o <= 1'b0;
            bus.bus_stb_o <= 1'b0;
            bus.bus_we_o  <= 1'b0;
            ir_o          <= ir_i;
            pc_o          <= pc_i;
            result_o      <= bus.bus_we_o ? result_i : ldat;
            reg_write_o   <= abort ? 2'b00 : reg_write_i;
            halt_o        <= halt_i;
            fault_o       <= abort;
            state         <= IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalign, bus error, reset.
// Expected values are hand-computed constants.
module tb_mem_access;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [63:0] ir_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] result_i = '0;
  logic [31:0] reg_data1_i = '0;
  logic [1:0]  reg_write_i = '0;
  logic        halt_i = 0;
  logic [63:0] ir_o;
  logic [31:0] pc_o;
  logic [31:0] result_o;
  logic [1:0]  reg_write_o;
  logic        halt_o;
  logic        stall_o;
  logic        fault_o;
  int          checks = 0;
  int          errors = 0;
  int          nstall;

  mem_access_if bus ();

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ir_i(ir_i), .pc_i(pc_i), .result_i(result_i),
    .reg_data1_i(reg_data1_i), .reg_write_i(reg_write_i),
    .halt_i(halt_i), .ir_o(ir_o), .pc_o(pc_o),
    .result_o(result_o), .reg_write_o(reg_write_o),
    .halt_o(halt_o), .stall_o(stall_o), .fault_o(fault_o),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] typ, input logic [3:0] op,
                       input logic [31:0] pc, input logic [31:0] res,
                       input logic [31:0] d, input logic [1:0] rw);
    ir_i        = {32'h0, typ, op, 24'h000001};
    pc_i        = pc;
    result_i    = res;
    reg_data1_i = d;
    reg_write_i = rw;
    #1;
  endtask

  task automatic bus_in(input logic a, input logic e,
                        input logic [31:0] d);
    bus.bus_ack_i = a;
    bus.bus_err_i = e;
    bus.bus_dat_i = d;
    #1;
  endtask

  initial begin
    bus.bus_ack_i = 0;
    bus.bus_err_i = 0;
    bus.bus_dat_i = '0;
    #12;
    check("rst_result", result_o, 0);
    check("rst_cyc", bus.bus_cyc_o, 0);
    check("rst_rw", reg_write_o, 0);
    check("rst_stall", stall_o, 0);
    rst_n = 1;
    step();

    // ALU pass-through
    drive(4'h9, 4'h0, 32'h100, 32'h55, 0, 2'b01);
    check("alu_stall", stall_o, 0);
    step();
    check("alu_res", result_o, 32'h55);
    check("alu_pc", pc_o, 32'h100);
    check("alu_rw", reg_write_o, 2'b01);
    check("alu_ir", ir_o, 64'h0000_0000_9000_0001);

    // word load 0x1000, ack on 4th cycle
    drive(4'ha, 4'h0, 32'h104, 32'h1000, 0, 2'b01);
    nstall = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall_o) nstall++;
      if (i == 1) begin
        check("wl_cyc", bus.bus_cyc_o, 1);
        check("wl_sel", bus.bus_sel_o, 4'b1111);
        check("wl_adr", bus.bus_adr_o, 32'h1000);
      end
      step();
    end
    bus_in(1, 0, 32'hDEADBEEF);
    check("wl_stall_ack", stall_o, 0);
    check("wl_nstall", nstall, 3);
    step();
    bus_in(0, 0, 0);
    check("wl_res", result_o, 32'hDEADBEEF);
    check("wl_rw", reg_write_o, 2'b01);
    check("wl_cyc_off", bus.bus_cyc_o, 0);

    // byte store 0x12345678 -> 0x2003
    drive(4'hb, 4'h2, 32'h108, 32'h2003, 32'h12345678, 2'b00);
    check("bs_stall", stall_o, 1);
    step();
    check("bs_we", bus.bus_we_o, 1);
    check("bs_adr", bus.bus_adr_o, 32'h2000);
    check("bs_sel", bus.bus_sel_o, 4'b0001);
    check("bs_dat", bus.bus_dat_o, 32'h78787878);
    bus_in(1, 0, 0);
    step();
    bus_in(0, 0, 0);
    check("bs_res", result_o, 32'h2003);
    check("bs_stb_off", bus.bus_stb_o, 0);

    // half load 0x3002
    drive(4'ha, 4'h1, 32'h10c, 32'h3002, 0, 2'b10);
    step();
    check("hl_sel", bus.bus_sel_o, 4'b0011);
    bus_in(1, 0, 32'hAAAA5555);
    step();
    bus_in(0, 0, 0);
    check("hl_res", result_o, 32'h00005555);

    // half store 0xBEEF at 0x3000 (upper half)
    drive(4'hb, 4'h1, 32'h110, 32'h3000, 32'h1234BEEF, 2'b00);
    step();
    check("hs_sel", bus.bus_sel_o, 4'b1100);
    check("hs_dat", bus.bus_dat_o, 32'hBEEFBEEF);
    bus_in(1, 0, 0);
    step();
    bus_in(0, 0, 0);

    // byte load at offset 1 -> lane [23:16]
    drive(4'ha, 4'h2, 32'h114, 32'h3001, 0, 2'b01);
    step();
    check("bl_sel", bus.bus_sel_o, 4'b0100);
    bus_in(1, 0, 32'h11223344);
    step();
    bus_in(0, 0, 0);
    check("bl_res", result_o, 32'h00000022);

    // misaligned word load 0x4001
    drive(4'ha, 4'h0, 32'h118, 32'h4001, 0, 2'b01);
    check("mis_stall", stall_o, 0);
    step();
    check("mis_cyc", bus.bus_cyc_o, 0);
    check("mis_fault", fault_o, 1);
    check("mis_rw", reg_write_o, 0);
    drive(4'h9, 4'h0, 32'h11c, 32'h77, 0, 2'b01);
    step();
    check("mis_fault_end", fault_o, 0);

    // bus error on 2nd REQ cycle, then ALU op
    drive(4'ha, 4'h0, 32'h120, 32'h5000, 0, 2'b11);
    step();
    step();
    bus_in(1, 1, 32'hFFFF0000);
    check("err_stall", stall_o, 0);
    step();
    bus_in(0, 0, 0);
    check("err_fault", fault_o, 1);
    check("err_rw", reg_write_o, 0);
    check("err_cyc", bus.bus_cyc_o, 0);
    drive(4'h9, 4'h0, 32'h124, 32'h99, 0, 2'b01);
    check("err_next_stall", stall_o, 0);
    step();
    check("err_next_res", result_o, 32'h99);
    check("err_next_rw", reg_write_o, 2'b01);
    check("err_fault_end", fault_o, 0);

`ifdef BUS_TIMEOUT_EN
    // no ack: abort on the 4th REQ cycle
    drive(4'ha, 4'h0, 32'h128, 32'h6000, 0, 2'b01);
    step();
    for (int i = 0; i < 3; i++) begin
      check("tmo_wait", stall_o, 1);
      step();
    end
    check("tmo_stall", stall_o, 0);
    step();
    check("tmo_fault", fault_o, 1);
    check("tmo_rw", reg_write_o, 0);
    check("tmo_cyc", bus.bus_cyc_o, 0);
    drive(4'h9, 4'h0, 32'h12c, 32'h1, 0, 2'b00);
    step();
`endif

    // reset during an outstanding request
    drive(4'ha, 4'h0, 32'h130, 32'h7000, 0, 2'b01);
    step();
    check("rr_cyc_pre", bus.bus_cyc_o, 1);
    rst_n = 0;
    #1;
    check("rr_cyc", bus.bus_cyc_o, 0);
    check("rr_fault", fault_o, 0);
    drive(4'h9, 4'h0, 32'h134, 32'h3, 0, 2'b01);
    step();
    rst_n = 1;
    step();
    check("rr_idle_res", result_o, 32'h3);
    check("rr_idle_cyc", bus.bus_cyc_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
